clk_gen_ctrl: RTL and testbench

Clock-domain control stage directly downstream of the differential-to-single-ended clock buffer. Consumes the buffered 200 MHz board clock and produces a synchronized reset, a free-running divider bus for display/scan logic, and a one-cycle CPU clock-enable. The clock-enable comes either from a selectable power-of-two divider (run mode) or from a debounced push-button (single-step mode). All downstream CPU and peripheral logic runs on `clk` and is qualified by `cpu_ce`.

---
 rtl/clk_gen_ctrl.sv | 108 ++++++++++
 tb/tb_clk_gen_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/clk_gen_ctrl.sv
// Clock-domain control: reset synchronizer, free-running divider and CPU clock-enable.
// Single-step debounce logic is compiled in only when CLK_GEN_STEP_EN is defined.
module clk_gen_ctrl #(
  parameter int CNT_W           = 32,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             step_mode,
  input  logic             step_btn,
  input  logic [4:0]       div_sel,
  output logic             rst_sync_n,
  output logic [CNT_W-1:0] clkdiv,
  output logic             cpu_ce
);

  logic             rst_meta;
  logic [CNT_W-1:0] mask;
  logic             run_hit;
  logic             ce_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) {rst_sync_n, rst_meta} <= 2'b00;
    else       {rst_sync_n, rst_meta} <= {rst_meta, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) clkdiv <= '0;
    else             clkdiv <= clkdiv + CNT_W'(1);
  end

  // Selects would exceed CNT_W saturate to the full counter: one pulse per wrap.
  always_comb begin
    mask = '0;
    for (int i = 0; i < CNT_W; i++) mask[i] = (i <= int'(div_sel));
  end

  assign run_hit = ((clkdiv & mask) == mask);

`ifdef CLK_GEN_STEP_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} db_state_t;

  db_state_t       state;
  logic [1:0]      mode_sr, btn_sr;
  logic            mode_s, btn_s;
  logic [DB_W-1:0] db_cnt;
  logic            step_pulse;

  assign mode_s = mode_sr[1];
  assign btn_s  = btn_sr[1];

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      mode_sr    <= 2'b00;
      btn_sr     <= 2'b00;
      state      <= IDLE;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      mode_sr    <= {mode_sr[0], step_mode};
      btn_sr     <= {btn_sr[0], step_btn};
      step_pulse <= 1'b0;
      if (!mode_s) begin
        state  <= IDLE;
        db_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (btn_s) begin
            state  <= PRESS_CHK;
            db_cnt <= '0;
          end
          PRESS_CHK:
            if (!btn_s) state <= IDLE;
            else if (db_cnt == DB_LAST) begin
              state      <= HELD;
              step_pulse <= 1'b1;
            end else db_cnt <= db_cnt + DB_W'(1);
          HELD: if (!btn_s) begin
            state  <= REL_CHK;
            db_cnt <= '0;
          end
          REL_CHK:
            if (btn_s) state <= HELD;
            else if (db_cnt == DB_LAST) state <= IDLE;
            else db_cnt <= db_cnt + DB_W'(1);
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A step pulse caught by a mode change is dropped rather than replayed.
  assign ce_nxt = mode_s ? step_pulse : run_hit;
`else
  logic unused_step;
  assign unused_step = step_mode ^ step_btn;
  assign ce_nxt      = run_hit;
`endif

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) cpu_ce <= 1'b0;
    else             cpu_ce <= ce_nxt;
  end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Directed bench for clk_gen_ctrl: run-mode vector table plus step-mode sequences
// (the latter only when CLK_GEN_STEP_EN is defined).
module tb_clk_gen_ctrl;
  localparam int CW = 8;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          step_mode = 1'b0;
  logic          step_btn = 1'b0;
  logic [4:0]    div_sel = 5'd0;
  logic          rst_sync_n;
  logic [CW-1:0] clkdiv;
  logic          cpu_ce;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_gen_ctrl #(.CNT_W(CW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rstn(rstn), .step_mode(step_mode), .step_btn(step_btn),
    .div_sel(div_sel), .rst_sync_n(rst_sync_n), .clkdiv(clkdiv), .cpu_ce(cpu_ce)
  );

  typedef struct {
    logic [4:0] ds;
    int         cyc;
    int         npulse;
    int         first;
    int         last;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply pat[i] to step_btn before edge i+1; record pulses by sample index.
  task automatic btn_seq(input logic [63:0] pat, input int n, output int np, output int first);
    np = 0;
    first = 0;
    for (int i = 0; i < n; i++) begin
      step_btn = pat[i];
      @(negedge clk);
      if (cpu_ce) begin
        if (np == 0) first = i + 1;
        np++;
      end
    end
  endtask

  task automatic run_window(input int cyc, input logic wiggle,
                            output int np, output int first, output int last,
                            output int adj, output logic [1:0] rel);
    logic prev;
    np = 0; first = 0; last = 0; adj = 0; prev = 1'b0; rel = 2'b00;
    rstn = 1'b1;
    for (int k = 1; k <= cyc; k++) begin
      if (wiggle) begin
        step_mode = k[1];
        step_btn  = k[0];
      end
      @(negedge clk);
      if (k == 1) rel[1] = rst_sync_n;
      if (k == 2) rel[0] = rst_sync_n;
      if (cpu_ce) begin
        if (prev) adj++;
        if (np == 0) first = int'(clkdiv);
        last = int'(clkdiv);
        np++;
      end
      prev = cpu_ce;
    end
  endtask

  initial begin
    int np, first, last, adj, total;
    logic [1:0] rel;

    vecs[0] = '{5'd0, 40, 19, 2, 38};
    vecs[1] = '{5'd1, 40, 9, 4, 36};
    vecs[2] = '{5'd2, 40, 4, 8, 32};
    vecs[3] = '{5'd3, 40, 2, 16, 32};
    vecs[4] = '{5'd4, 40, 1, 32, 32};
    vecs[5] = '{5'd7, 300, 1, 0, 0};
    vecs[6] = '{5'd3, 300, 18, 16, 32};

    repeat (3) @(negedge clk);
    check("reset_rst_sync_n", rst_sync_n, 0);
    check("reset_clkdiv", clkdiv, 0);
    check("reset_cpu_ce", cpu_ce, 0);

    for (int v = 0; v < 7; v++) begin
      rstn = 1'b0;
      #1;
      if (v > 0) check("async_rst_clkdiv", clkdiv, 0);
      div_sel = vecs[v].ds;
      @(negedge clk);
      run_window(vecs[v].cyc, 1'b0, np, first, last, adj, rel);
      check("rst_release", rel, 2'b01);
      check("run_npulse", np, vecs[v].npulse);
      check("run_first", first, vecs[v].first);
      check("run_last", last, vecs[v].last);
      check("run_adjacent", adj, 0);
    end

`ifdef CLK_GEN_STEP_EN
    // Step mode with a fast run divider: run pulses must vanish.
    rstn = 1'b0;
    div_sel = 5'd0;
    step_mode = 1'b1;
    step_btn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    btn_seq(64'h0, 16, np, first);
    check("step_run_suppressed", np, 0);

    btn_seq(64'hFFFFF, 20, np, first);
    check("press_npulse", np, 1);
    check("press_latency", first, 8);
    btn_seq(64'h0, 12, np, first);
    check("release_npulse", np, 0);

    total = 0;
    btn_seq(64'hFFFB, 16, np, first);
    total += np;
    check("bounce_latency", first, 11);
    btn_seq(64'h2, 12, np, first);
    total += np;
    btn_seq(64'hFFFFF, 20, np, first);
    total += np;
    check("bounce_second_latency", first, 8);
    check("bounce_total", total, 2);
    btn_seq(64'h0, 12, np, first);

    // Reset while in PRESS_CHK discards the press.
    div_sel = 5'd7;
    btn_seq(64'hF, 4, np, first);
    rstn = 1'b0;
    #1;
    check("midpress_rst_cpu_ce", cpu_ce, 0);
    check("midpress_rst_clkdiv", clkdiv, 0);
    check("midpress_rst_sync", rst_sync_n, 0);
    step_btn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    btn_seq(64'h0, 12, np, first);
    check("midpress_no_pulse", np, 0);
    btn_seq(64'hFFFFF, 20, np, first);
    check("midpress_new_press", np, 1);
    check("midpress_new_latency", first, 8);
`else
    // Step inputs are ignored: identical to the div_sel=0 run vector.
    rstn = 1'b0;
    div_sel = 5'd0;
    @(negedge clk);
    run_window(40, 1'b1, np, first, last, adj, rel);
    check("macro_off_npulse", np, 19);
    check("macro_off_first", first, 2);
    check("macro_off_last", last, 38);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
